alu_sequencer: RTL and testbench

- Command-side initiator for the team's registered 8-bit ALU (2-bit op_code: 0 add/sub with Cin, 1 XOR, 2 decrement).
- Accepts operation commands from a host over a valid/ready handshake and drives the ALU operand/op pins, holding them stable for the ALU's latency.
- Captures the ALU result and carry, then returns them to the host over a second valid/ready handshake.
- Optional chaining feeds the previous result back as operand A.

---
 rtl/alu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command/response initiator for the registered 8-bit ALU
//
// Accepts one ALU command at a time from the host and drives the ALU pins.
// It holds those pins for LATENCY edges, captures the result and carry, and
// returns them over a response handshake.
//
// Optional feature: define ALU_SEQ_FLAGS_EN to add rsp_flags = {negative, zero}.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_op, cmd_a, cmd_b       ALU op_code and operands
//   cmd_cin, cmd_chain         carry-in / subtract select; use last result as A
//   alu_a, alu_b, alu_op,
//   alu_cin                    registered drive to the ALU
//   alu_out, alu_cout          ALU result and carry
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_carry        captured result and carry
//   rsp_flags                  {negative, zero} of rsp_data (ALU_SEQ_FLAGS_EN only)
//   busy                       high whenever a command is in flight
module alu_sequencer #(
  parameter int LATENCY = 3,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
`ifdef ALU_SEQ_FLAGS_EN
  output logic [1:0]       rsp_flags,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

  // A 4-bit counter covers the full legal LATENCY range of 2..15.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] last_q, last_d;
`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0]       flags_q, flags_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      last_q      <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_cin_q   <= alu_cin_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_valid_q <= rsp_valid_d;
      last_q      <= last_d;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_cin_d   = alu_cin_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_valid_d = rsp_valid_q;
    last_d      = last_q;
`ifdef ALU_SEQ_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      IDLE: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone is the handshake.
        if (cmd_valid) begin
          alu_op_d  = cmd_op;
          alu_b_d   = cmd_b;
          alu_cin_d = cmd_cin;
          alu_a_d   = cmd_chain ? last_q : cmd_a;
          cnt_d     = LAT_M1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        // The ALU drive registers stay frozen here. The ALU result and its
        // lagging carry have both settled by the time the counter reaches 0.
        if (cnt_q == 4'd0) begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_cout;
          last_d      = alu_out;
          rsp_valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
          flags_d     = {alu_out[WIDTH-1], (alu_out == '0)};
`endif
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_cin   = alu_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign rsp_flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a registered ALU model
module tb_alu_sequencer;
  localparam int L = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic         cmd_cin = 1'b0, cmd_chain = 1'b0;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_op;
  logic         alu_cin;
  logic [W-1:0] alu_out;
  logic         alu_cout;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_carry;
`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0]   rsp_flags;
`endif
  logic         busy;

  always #5 clk = ~clk;

  alu_sequencer #(.LATENCY(L), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_flags(rsp_flags),
`endif
    .busy(busy)
  );

  // Registered ALU: out one edge after its inputs, Cout one further edge later.
  logic         c1;
  logic [W:0]   s9;
  always_comb begin
    s9 = '0;
    case (alu_op)
      2'd0: s9 = alu_cin ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1)
                         : ({1'b0, alu_a} + {1'b0, alu_b});
      2'd1: s9 = {1'b0, alu_a ^ alu_b};
      2'd2: s9 = {1'b0, alu_a} + 9'h0FF;
      default: s9 = {1'b0, alu_out};
    endcase
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out <= '0; c1 <= 1'b0; alu_cout <= 1'b0;
    end else begin
      alu_out  <= s9[W-1:0];
      c1       <= s9[W];
      alu_cout <= c1;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int ref_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: result/carry from the op's arithmetic meaning on plain integers.
  task automatic ref_calc(input int op, input int a, input int b, input int cin,
                          output int d, output int c);
    case (op)
      0: if (cin != 0) begin d = (a - b) & 255; c = (a >= b) ? 1 : 0; end
         else begin d = (a + b) & 255; c = (a + b > 255) ? 1 : 0; end
      1: begin d = a ^ b; c = 0; end
      2: begin d = (a + 255) & 255; c = (a != 0) ? 1 : 0; end
      default: begin d = ref_last; c = 0; end
    endcase
  endtask

  // Issue a command, check the ALU pins at accept and the accept-to-valid latency.
  task automatic issue(input int op, input int a, input int b, input int cin,
                       input int chain, output int ed, output int ec);
    int n;
    int ea;
    ea = (chain != 0) ? ref_last : a;
    ref_calc(op, ea, b, cin, ed, ec);
    @(negedge clk);
    cmd_op = op[1:0]; cmd_a = a[W-1:0]; cmd_b = b[W-1:0];
    cmd_cin = cin[0]; cmd_chain = chain[0]; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("alu_a", int'(alu_a), ea);
    chk("alu_b", int'(alu_b), b);
    chk("alu_op", int'(alu_op), op);
    chk("alu_cin", int'(alu_cin), cin);
    chk("busy_hold", int'(busy), 1);
    n = 1;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency_edges", n, L + 1);
  endtask

  // Check the response, hold off rsp_ready for 'hold' cycles, then complete it.
  task automatic collect(input int hold, input int ed, input int ec);
    logic [W-1:0] sa;
    sa = alu_a;
    chk("rsp_data", int'(rsp_data), ed);
    chk("rsp_carry", int'(rsp_carry), ec);
`ifdef ALU_SEQ_FLAGS_EN
    chk("rsp_flags", int'(rsp_flags), ((ed >> 7) & 1) * 2 + ((ed == 0) ? 1 : 0));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_data", int'(rsp_data), ed);
      chk("bp_carry", int'(rsp_carry), ec);
      chk("bp_cmd_ready", int'(cmd_ready), 0);
      chk("bp_alu_a", int'(alu_a), int'(sa));
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("rsp_done_valid", int'(rsp_valid), 0);
    chk("rsp_done_cmd_ready", int'(cmd_ready), 1);
    ref_last = ed;
  endtask

  typedef struct {
    int op; int a; int b; int cin; int chain; int hold; int ed; int ec;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int ed, ec;
    vecs[0] = '{0, 8'h05, 8'h03, 0, 0, 0, 8'h08, 0};
    vecs[1] = '{0, 8'h10, 8'h01, 1, 0, 1, 8'h0F, 1};
    vecs[2] = '{0, 8'hFF, 8'h01, 0, 0, 2, 8'h00, 1};
    vecs[3] = '{2, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 0};
    vecs[4] = '{1, 8'h00, 8'h0F, 0, 1, 1, 8'hF0, 0};
    vecs[5] = '{1, 8'h33, 8'h0F, 0, 0, 0, 8'h3C, 0};
    vecs[6] = '{3, 8'h00, 8'h00, 0, 0, 3, 8'h3C, 0};
    vecs[7] = '{2, 8'h00, 8'h00, 0, 1, 0, 8'h3B, 1};

    // Reset state.
    #12;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_carry", int'(rsp_carry), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].chain, ed, ec);
      collect(vecs[i].hold, vecs[i].ed, vecs[i].ec);
    end

    // Backpressure with a competing command pending during RESP.
    issue(0, 8'h21, 8'h12, 0, 0, ed, ec);
    @(negedge clk);
    cmd_op = 2'd1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_cin = 1'b0; cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    collect(10, 8'h33, 0);
    issue(1, 8'hAA, 8'h55, 0, 0, ed, ec);
    collect(0, 8'hFF, 0);

    // Asynchronous reset in the middle of HOLD.
    @(negedge clk);
    cmd_op = 2'd0; cmd_a = 8'h40; cmd_b = 8'h02; cmd_cin = 1'b0; cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #3; reset = 1'b1; #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
    chk("mid_rst_alu_a", int'(alu_a), 0);
    chk("mid_rst_alu_b", int'(alu_b), 0);
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_rsp_data", int'(rsp_data), 0);
    @(negedge clk); reset = 1'b0;
    ref_last = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", int'(rsp_valid), 0);
    end
    issue(1, 8'h99, 8'h5A, 0, 1, ed, ec);
    collect(0, 8'h5A, 0);

    // Randomized commands against the reference model.
    for (int i = 0; i < 150; i++) begin
      issue(int'($urandom_range(3, 0)), int'($urandom_range(255, 0)),
            int'($urandom_range(255, 0)), int'($urandom_range(1, 0)),
            ($urandom_range(3, 0) == 0) ? 1 : 0, ed, ec);
      collect(int'($urandom_range(3, 0)), ed, ec);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
